stage2_block_framer: RTL and testbench

Stage-2 framer directly downstream of the stage-2 block-size decoder. It accepts one block length per transfer from the decoder's `block_size_data`, then passes exactly that many payload bytes from the upstream byte stream to the output. Output bytes carry start-of-block and end-of-block markers. It also keeps a running count of completed blocks and a sticky flag for illegal lengths.

---
 rtl/stage2_block_framer.sv | 79 +++++++
 tb/tb_stage2_block_framer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage2_block_framer.sv
// stage2_block_framer: takes one block length from the block-size decoder, then forwards
// exactly that many payload bytes with sof/eof markers through a one-deep output register.
module stage2_block_framer #(
    parameter int DATA_W   = 8,
    parameter int SIZE_W   = 7,
    parameter int MIN_SIZE = 22,
    parameter int MAX_SIZE = 126,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SIZE_W-1:0] size_data,
    input  logic              size_valid,
    output logic              size_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic [CNT_W-1:0]  blocks_done,
    output logic              size_err
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nxt;
    logic [SIZE_W-1:0] remaining;
    logic first, legal, last, take_size, take_byte;
    assign legal      = (size_data >= SIZE_W'(MIN_SIZE)) && (size_data <= SIZE_W'(MAX_SIZE));
    assign last       = remaining == SIZE_W'(1);
    // size_ready is held low while reset is asserted so every output reads 0 during reset
    assign size_ready = rst_n && (state == IDLE);
    assign in_ready   = (state == STREAM) && (!out_valid || out_ready);
    assign take_size  = size_valid && size_ready;
    assign take_byte  = in_valid && in_ready;
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (take_size && legal) ? STREAM : IDLE;
        else
            state_nxt = (take_byte && last) ? IDLE : STREAM;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            first       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            blocks_done <= '0;
            size_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_size) begin
                if (legal) begin
                    remaining <= size_data;
                    first     <= 1'b1;
                end else begin
                    size_err  <= 1'b1;
                end
            end
            if (take_byte) begin
                out_data  <= in_data;
                out_sof   <= first;
                out_eof   <= last;
                out_valid <= 1'b1;
                first     <= 1'b0;
                remaining <= remaining - SIZE_W'(1);
                if (last)
                    blocks_done <= blocks_done + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stage2_block_framer.sv
// tb_stage2_block_framer: directed bench for the framer; a narrow-counter instance shares
// the stimulus so counter wrap can be exercised in a short run.
module tb_stage2_block_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] size_data = '0;
    logic       size_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       size_ready, in_ready, out_valid, out_sof, out_eof, size_err;
    logic [7:0] out_data;
    logic [15:0] blocks_done;
    logic       w_size_ready, w_in_ready, w_out_valid, w_out_sof, w_out_eof, w_size_err;
    logic [7:0] w_out_data;
    logic [2:0] w_blocks_done;

    int   n_pass = 0;
    int   n_total = 0;
    int   stall_err = 0;
    bit   rnd = 1'b0;
    logic [9:0]  exp_q[$];
    logic [9:0]  got_q[$];
    logic        hold_pending = 1'b0;
    logic [10:0] held = '0;

    stage2_block_framer dut (
        .clk(clk), .rst_n(rst_n), .size_data(size_data), .size_valid(size_valid),
        .size_ready(size_ready), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eof(out_eof), .blocks_done(blocks_done), .size_err(size_err)
    );

    stage2_block_framer #(.CNT_W(3)) u_wrap (
        .clk(clk), .rst_n(rst_n), .size_data(size_data), .size_valid(size_valid),
        .size_ready(w_size_ready), .in_data(in_data), .in_valid(in_valid), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(out_ready), .out_sof(w_out_sof),
        .out_eof(w_out_eof), .blocks_done(w_blocks_done), .size_err(w_size_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    // Collect delivered bytes and flag any output change while stalled
    always @(negedge clk) begin
        if (rst_n && hold_pending && {out_valid, out_sof, out_eof, out_data} != held)
            stall_err <= stall_err + 1;
        hold_pending <= rst_n && out_valid && !out_ready;
        held <= {out_valid, out_sof, out_eof, out_data};
        if (rst_n && out_valid && out_ready)
            got_q.push_back({out_sof, out_eof, out_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_size(input int s, output int cyc);
        logic took;
        cyc = 0;
        size_data = 7'(s);
        size_valid = 1'b1;
        do begin
            took = size_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!took && cyc < 1000);
        size_valid = 1'b0;
        if (!took) check("size_timeout", 32'(took), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int t = 0;
        logic took;
        in_data = d;
        in_valid = 1'b1;
        do begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            took = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!took && t < 1000);
        in_valid = 1'b0;
        if (took) exp_q.push_back({s, e, d});
        else check("byte_timeout", 32'(took), 32'd1);
    endtask

    task automatic send_block(input int n, input int base);
        int c;
        send_size(n, c);
        for (int i = 0; i < n; i++) send_byte(8'(base + i), i == 0, i == n - 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int c;
        #1;
        check("rst_outputs", {size_ready, in_ready, out_valid, out_sof, out_eof, out_data, size_err},
              32'd0);
        check("rst_blocks", 32'(blocks_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_ready", {size_ready, in_ready}, 32'b10);
        @(posedge clk); #1;

        // length 22, bytes 0x00..0x15, checked cycle by cycle
        send_size(22, c);
        for (int i = 0; i < 22; i++) begin
            in_data = 8'(i);
            in_valid = 1'b1;
            out_ready = 1'b1;
            #1;
            check("t1_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            check("t1_out", {out_valid, out_sof, out_eof, out_data},
                  {1'b1, i == 0, i == 21, 8'(i)});
        end
        in_valid = 1'b0;
        check("t1_blocks", 32'(blocks_done), 32'd1);
        check("t1_idle", {size_ready, in_ready, size_err}, 32'b100);
        drain();
        got_q.delete();

        // 126 then 34, random backpressure
        rnd = 1'b1;
        send_block(126, 0);
        send_block(34, 126);
        rnd = 1'b0;
        drain();
        check("t2_eof126", 32'(exp_q[125][8]), 32'd1);
        cmp_q("t2");
        check("t2_blocks", 32'(blocks_done), 32'd3);

        // illegal lengths are consumed in one cycle each and flagged
        send_size(21, c);
        check("t3_take21", 32'(c), 32'd1);
        send_size(0, c);
        check("t3_take0", 32'(c), 32'd1);
        send_size(127, c);
        check("t3_take127", 32'(c), 32'd1);
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (3) begin
            #1;
            check("t3_no_accept", {in_ready, out_valid, size_ready}, 32'b001);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t3_size_err", 32'(size_err), 32'd1);
        check("t3_blocks", 32'(blocks_done), 32'd3);
        send_block(44, 8'h30);
        drain();
        cmp_q("t3");
        check("t3_blocks_after", 32'(blocks_done), 32'd4);

        // 10-cycle downstream stall inside a 56-byte block
        send_size(56, c);
        for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i), i == 0, 1'b0);
        out_ready = 1'b0;
        in_data = 8'h54;
        in_valid = 1'b1;
        repeat (10) begin
            #1;
            check("t4_stall", {in_ready, out_valid, out_data}, {1'b0, 1'b1, 8'h53});
            @(posedge clk); #1;
        end
        for (int i = 20; i < 56; i++) send_byte(8'(8'h40 + i), 1'b0, i == 55);
        drain();
        cmp_q("t4");
        check("t4_blocks", 32'(blocks_done), 32'd5);
        check("t4_size_err_sticky", 32'(size_err), 32'd1);
        check("stall_stable", 32'(stall_err), 32'd0);

        // asynchronous reset after 30 of 100 bytes
        send_size(100, c);
        for (int i = 0; i < 30; i++) send_byte(8'(8'h80 + i), i == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outputs", {size_ready, in_ready, out_valid, out_sof, out_eof, out_data, size_err},
              32'd0);
        check("t5_rst_blocks", 32'(blocks_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("t5_post_rst", {size_ready, in_ready}, 32'b10);
        @(posedge clk); #1;
        got_q.delete();
        exp_q.delete();
        send_block(22, 8'hA0);
        drain();
        cmp_q("t5");
        check("t5_blocks", 32'(blocks_done), 32'd1);

        // counter wrap on the 3-bit instance
        repeat (6) send_block(22, 8'h10);
        drain();
        check("t6_before_wrap", {w_blocks_done, blocks_done}, {3'd7, 16'd7});
        send_block(22, 8'h10);
        drain();
        check("t6_wrap", {w_blocks_done, blocks_done}, {3'd0, 16'd8});
        cmp_q("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
